uart_rx_wrapper: RTL and testbench



---
 rtl/uart_rx_wrapper.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_wrapper.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_wrapper.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling FSM, RX FIFO. A byte enters the FIFO at mid-stop-bit.
// Reads return data one cycle after rd_en. When the FIFO is full, new bytes are dropped with an overflow pulse.
module uart_rx_wrapper #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          UART_clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic                          rx_enable,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          data_out,
    output logic                          rd_ack,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow,
    output logic                          frame_error,
    output logic                          rx_done_tick
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic                 rx_meta_q;
    logic                 rx_s_q;

    state_t               state_q;
    logic [TW-1:0]        tick_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 rx_done_q;
    logic                 frame_err_q;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_d;
    logic [DATA_BITS-1:0] data_out_q;
    logic                 rd_ack_q;
    logic                 overflow_q;
    logic                 underflow_q;

    logic                 push_c;
    logic                 rd_ok;
    logic                 wr_ok;

    // Idle-high line: synchroniser resets to 1 so reset release never looks like a start bit.
    always_ff @(posedge UART_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge UART_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tick_q <= '0;
                    if (rx_enable && !rx_s_q) begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (tick_q == TICK_HALF) begin
                        tick_q  <= '0;
                        bit_q   <= '0;
                        state_q <= rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_q         <= '0;
                        shift_q[bit_q] <= rx_s_q;
                        if (bit_q == BIT_LAST) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_q      <= '0;
                        rx_done_q   <= 1'b1;
                        frame_err_q <= ~rx_s_q;
                        state_q     <= S_IDLE;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // A read in the same cycle frees a slot, so a push into a full FIFO still succeeds.
    assign push_c = (state_q == S_STOP) && (tick_q == TICK_LAST) && rx_s_q;
    assign rd_ok  = rd_en && (count_q != '0);
    assign wr_ok  = push_c && ((count_q != CNT_FULL) || rd_ok);

    always_comb begin
        count_d = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + 1'b1;
        end else if (!wr_ok && rd_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge UART_clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge UART_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            rd_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            rd_ack_q    <= rd_ok;
            underflow_q <= rd_en && !rd_ok;
            overflow_q  <= push_c && !wr_ok;
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                data_out_q <= mem_q[rd_ptr_q];
                rd_ptr_q   <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign data_out     = data_out_q;
    assign rd_ack       = rd_ack_q;
    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_FULL);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign frame_error  = frame_err_q;
    assign rx_done_tick = rx_done_q;

endmodule

// File: tb/tb_uart_rx_wrapper.sv
// Bench for uart_rx_wrapper: serial frames are driven from a behavioural transmitter and checked against a queue model.
`timescale 1ns/1ps
module tb_uart_rx_wrapper;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CPB;
    // Reset outputs are packed as {data_out, rd_ack, empty, full, count, overflow, underflow, frame_error, rx_done_tick}.
    localparam logic [19:0] RESET_VEC = {8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 4'b0000};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_enable = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] data_out;
    logic       rd_ack, empty, full, overflow, underflow, frame_error, rx_done_tick;
    logic [4:0] count;

    always #5 clk = ~clk;

    uart_rx_wrapper #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .FIFO_DEPTH(DEPTH)) dut (
        .UART_clk(clk), .rst_n(rst_n), .rx(rx), .rx_enable(rx_enable), .rd_en(rd_en),
        .data_out(data_out), .rd_ack(rd_ack), .empty(empty), .full(full), .count(count),
        .overflow(overflow), .underflow(underflow), .frame_error(frame_error),
        .rx_done_tick(rx_done_tick)
    );

    int pass_n = 0;
    int total_n = 0;
    int done_n = 0, ferr_n = 0, ovf_n = 0, unf_n = 0, ferr_solo_n = 0;

    // Reference model: bytes the receiver should have accepted, in arrival order.
    logic [7:0] q_m[$];
    int exp_done = 0, exp_ferr = 0, exp_ovf = 0;
    logic [7:0] last_data = 8'h00;

    always @(posedge clk) begin
        #1;
        if (rx_done_tick) done_n++;
        if (frame_error) ferr_n++;
        if (overflow) ovf_n++;
        if (underflow) unf_n++;
        if (frame_error && !rx_done_tick) ferr_solo_n++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int limit);
        logic [9:0] fr;
        int cyc;
        fr  = {stop, b, 1'b0};
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            for (int k = 0; k < CPB; k++) begin
                @(negedge clk);
                cyc++;
                if (cyc >= limit) begin
                    rx = 1'b1;
                    return;
                end
            end
        end
        rx = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop);
        exp_done++;
        if (!stop) exp_ferr++;
        else if (q_m.size() == DEPTH) exp_ovf++;
        else q_m.push_back(b);
    endtask

    task automatic read_pulse();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total_n++;
        if ({data_out, rd_ack, empty, full, count, overflow, underflow, frame_error, rx_done_tick} !== RESET_VEC)
            $display("FAIL reset_in: got %h want %h", {data_out, rd_ack, empty, full, count, overflow, underflow, frame_error, rx_done_tick}, RESET_VEC);
        else pass_n++;
        rst_n = 1'b1;
        idle(2 * CPB);
        total_n++;
        if ({data_out, rd_ack, empty, full, count, overflow, underflow, frame_error, rx_done_tick} !== RESET_VEC)
            $display("FAIL reset_idle: got %h want %h", {data_out, rd_ack, empty, full, count, overflow, underflow, frame_error, rx_done_tick}, RESET_VEC);
        else pass_n++;
    endtask

    task automatic test_single();
        logic [7:0] e;
        send_frame(8'hA5, 1'b1, FRAME);
        model_frame(8'hA5, 1'b1);
        idle(4);
        total_n++;
        if (done_n !== exp_done) $display("FAIL single_done: got %0d want %0d", done_n, exp_done); else pass_n++;
        total_n++;
        if (count !== 5'(q_m.size()) || empty !== 1'b0) $display("FAIL single_count: got %0d/%b want %0d/0", count, empty, q_m.size()); else pass_n++;
        e = q_m.pop_front();
        read_pulse();
        last_data = e;
        total_n++;
        if (data_out !== e || rd_ack !== 1'b1 || empty !== 1'b1)
            $display("FAIL single_read: got %h ack %b empty %b want %h 1 1", data_out, rd_ack, empty, e);
        else pass_n++;
        @(negedge clk);
        total_n++;
        if (rd_ack !== 1'b0 || data_out !== e) $display("FAIL single_hold: got %h ack %b want %h 0", data_out, rd_ack, e); else pass_n++;
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(2 * CPB);
        total_n++;
        if (done_n !== exp_done || count !== 5'd0) $display("FAIL glitch: got done %0d count %0d want %0d 0", done_n, count, exp_done); else pass_n++;
    endtask

    task automatic test_enable_off();
        rx_enable = 1'b0;
        send_frame(8'h77, 1'b1, FRAME);
        idle(CPB);
        rx_enable = 1'b1;
        total_n++;
        if (done_n !== exp_done || count !== 5'd0) $display("FAIL enable_off: got done %0d count %0d want %0d 0", done_n, count, exp_done); else pass_n++;
    endtask

    task automatic test_frame_error();
        logic [7:0] e;
        send_frame(8'h3C, 1'b0, FRAME);
        model_frame(8'h3C, 1'b0);
        idle(2 * CPB);
        total_n++;
        if (ferr_n !== exp_ferr || done_n !== exp_done || count !== 5'd0)
            $display("FAIL frame_err: got ferr %0d done %0d count %0d want %0d %0d 0", ferr_n, done_n, count, exp_ferr, exp_done);
        else pass_n++;
        send_frame(8'h5A, 1'b1, FRAME);
        model_frame(8'h5A, 1'b1);
        idle(4);
        e = q_m.pop_front();
        read_pulse();
        last_data = e;
        total_n++;
        if (data_out !== e || rd_ack !== 1'b1) $display("FAIL after_ferr: got %h ack %b want %h 1", data_out, rd_ack, e); else pass_n++;
    endtask

    task automatic test_fill();
        logic [7:0] e;
        for (int i = 0; i <= DEPTH; i++) begin
            send_frame(8'(i), 1'b1, FRAME);
            model_frame(8'(i), 1'b1);
            idle(4);
            if (i == DEPTH - 1) begin
                total_n++;
                if (full !== 1'b1 || count !== 5'd16) $display("FAIL fill_full: got full %b count %0d want 1 16", full, count); else pass_n++;
            end
        end
        total_n++;
        if (ovf_n !== exp_ovf || count !== 5'd16) $display("FAIL fill_ovf: got ovf %0d count %0d want %0d 16", ovf_n, count, exp_ovf); else pass_n++;
        for (int i = 0; i < DEPTH; i++) begin
            e = q_m.pop_front();
            read_pulse();
            last_data = e;
            total_n++;
            if (data_out !== e || data_out !== 8'(i)) $display("FAIL fill_read%0d: got %h want %h", i, data_out, e); else pass_n++;
        end
        total_n++;
        if (empty !== 1'b1 || count !== 5'd0) $display("FAIL fill_empty: got empty %b count %0d want 1 0", empty, count); else pass_n++;
    endtask

    task automatic test_underflow();
        int u0;
        u0 = unf_n;
        read_pulse();
        total_n++;
        if (underflow !== 1'b1 || rd_ack !== 1'b0 || data_out !== last_data)
            $display("FAIL underflow: got unf %b ack %b data %h want 1 0 %h", underflow, rd_ack, data_out, last_data);
        else pass_n++;
        @(negedge clk);
        total_n++;
        if (unf_n !== u0 + 1 || count !== 5'd0) $display("FAIL underflow_cnt: got %0d count %0d want %0d 0", unf_n, count, u0 + 1); else pass_n++;
    endtask

    task automatic test_simul_full();
        logic [7:0] b, e;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1, FRAME);
            model_frame(b, 1'b1);
            idle(4);
        end
        b = 8'($urandom_range(0, 255));
        e = q_m.pop_front();
        model_frame(b, 1'b1);
        fork
            send_frame(b, 1'b1, FRAME);
            begin
                repeat (FRAME - 6) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
                total_n++;
                if (rd_ack !== 1'b1 || data_out !== e || overflow !== 1'b0 || rx_done_tick !== 1'b1 || count !== 5'd16)
                    $display("FAIL simul_full: got ack %b data %h ovf %b done %b count %0d want 1 %h 0 1 16",
                             rd_ack, data_out, overflow, rx_done_tick, count, e);
                else pass_n++;
            end
        join
        last_data = e;
        idle(4);
        total_n++;
        if (ovf_n !== exp_ovf) $display("FAIL simul_full_ovf: got %0d want %0d", ovf_n, exp_ovf); else pass_n++;
        while (q_m.size() > 0) begin
            e = q_m.pop_front();
            read_pulse();
            last_data = e;
            total_n++;
            if (data_out !== e) $display("FAIL simul_drain: got %h want %h", data_out, e); else pass_n++;
        end
    endtask

    task automatic test_simul_empty();
        logic [7:0] e;
        model_frame(8'h6E, 1'b1);
        fork
            send_frame(8'h6E, 1'b1, FRAME);
            begin
                repeat (FRAME - 6) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
                total_n++;
                if (underflow !== 1'b1 || rd_ack !== 1'b0 || count !== 5'd1 || data_out !== last_data)
                    $display("FAIL simul_empty: got unf %b ack %b count %0d data %h want 1 0 1 %h", underflow, rd_ack, count, data_out, last_data);
                else pass_n++;
            end
        join
        idle(4);
        e = q_m.pop_front();
        read_pulse();
        last_data = e;
        total_n++;
        if (data_out !== e) $display("FAIL simul_empty_read: got %h want %h", data_out, e); else pass_n++;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] e;
        send_frame(8'h96, 1'b1, 4 * CPB + CPB / 2);
        rst_n = 1'b0;
        #1;
        total_n++;
        if ({data_out, rd_ack, empty, full, count, overflow, underflow, frame_error, rx_done_tick} !== RESET_VEC)
            $display("FAIL midreset: got %h want %h", {data_out, rd_ack, empty, full, count, overflow, underflow, frame_error, rx_done_tick}, RESET_VEC);
        else pass_n++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        q_m.delete();
        idle(2 * CPB);
        total_n++;
        if (done_n !== exp_done || count !== 5'd0) $display("FAIL midreset_idle: got done %0d count %0d want %0d 0", done_n, count, exp_done); else pass_n++;
        send_frame(8'hC3, 1'b1, FRAME);
        model_frame(8'hC3, 1'b1);
        idle(4);
        e = q_m.pop_front();
        read_pulse();
        last_data = e;
        total_n++;
        if (data_out !== e || rd_ack !== 1'b1) $display("FAIL midreset_rx: got %h ack %b want %h 1", data_out, rd_ack, e); else pass_n++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        send_frame(8'h5A, 1'b1, FRAME);
        model_frame(8'h5A, 1'b1);
        send_frame(8'h3C, 1'b1, FRAME);
        model_frame(8'h3C, 1'b1);
        idle(4);
        total_n++;
        if (ferr_n !== exp_ferr || done_n !== exp_done) $display("FAIL b2b_status: got ferr %0d done %0d want %0d %0d", ferr_n, done_n, exp_ferr, exp_done); else pass_n++;
        for (int i = 0; i < 2; i++) begin
            e = q_m.pop_front();
            read_pulse();
            last_data = e;
            total_n++;
            if (data_out !== e) $display("FAIL b2b_read%0d: got %h want %h", i, data_out, e); else pass_n++;
        end
    endtask

    task automatic test_random();
        logic [7:0] b, e;
        logic stop;
        int u0;
        for (int it = 0; it < 24; it++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop, FRAME);
            model_frame(b, stop);
            idle(CPB);
            total_n++;
            if (done_n !== exp_done || ferr_n !== exp_ferr || ovf_n !== exp_ovf || count !== 5'(q_m.size()))
                $display("FAIL rand%0d_frame: got done %0d ferr %0d ovf %0d count %0d want %0d %0d %0d %0d",
                         it, done_n, ferr_n, ovf_n, count, exp_done, exp_ferr, exp_ovf, q_m.size());
            else pass_n++;
            if ($urandom_range(0, 1) == 1) begin
                u0 = unf_n;
                if (q_m.size() > 0) begin
                    e = q_m.pop_front();
                    read_pulse();
                    last_data = e;
                    total_n++;
                    if (data_out !== e || rd_ack !== 1'b1) $display("FAIL rand%0d_read: got %h ack %b want %h 1", it, data_out, rd_ack, e); else pass_n++;
                end else begin
                    read_pulse();
                    @(negedge clk);
                    total_n++;
                    if (unf_n !== u0 + 1 || data_out !== last_data) $display("FAIL rand%0d_unf: got %0d %h want %0d %h", it, unf_n, data_out, u0 + 1, last_data); else pass_n++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_enable_off();
        test_frame_error();
        test_fill();
        test_underflow();
        test_simul_full();
        test_simul_empty();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        total_n++;
        if (ferr_solo_n !== 0) $display("FAIL ferr_without_done: got %0d want 0", ferr_solo_n); else pass_n++;
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
